// File: rtl/norm_lut_arbiter_if.sv
// Request/response handshake bundle between the normalization lanes and the LUT arbiter.
// The master side is the requester/consumer side, and the slave side is the arbiter.
interface norm_lut_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          rsp_valid;
    logic [ID_WIDTH-1:0]           rsp_id;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          rsp_ready;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/norm_lut_arbiter.sv
// Round-robin sharing of one single-port, 1-cycle-latency norm LUT ROM among NUM_REQ lanes.
// Each read is tagged with its requester ID, and results return in order through a 3-entry FIFO.
module norm_lut_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    norm_lut_arbiter_if.slave     bus,
    output logic                  rom_reset,
    output logic                  rom_enable,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_data_out
);
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic                  s1_valid;
    logic [ID_WIDTH-1:0]   s1_id;
    logic [ID_WIDTH-1:0]   fifo_id   [4];
    logic [DATA_WIDTH-1:0] fifo_data [4];
    logic [1:0]            rd_ptr;
    logic [1:0]            wr_ptr;
    logic [1:0]            count;

    logic                  issue_ok;
    logic                  grant_any;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit is computed from registered state only, so req_ready never depends on rsp_ready.
    assign issue_ok = ({1'b0, count} + {2'b00, s1_valid}) <= 3'd2;

    always_comb begin
        int idx;
        bus.req_ready = '0;
        grant_any     = 1'b0;
        grant_id      = '0;
        idx           = 0;
        if (reset && issue_ok) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_REQ;
                if (!grant_any && bus.req_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_id  = ID_WIDTH'(idx);
                end
            end
        end
        if (grant_any) bus.req_ready[grant_id] = 1'b1;
    end

    assign rom_reset   = ~reset;
    assign rom_enable  = grant_any;
    assign rom_address = grant_any ? bus.req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH]
                                   : '0;

    assign bus.rsp_valid = reset && (count != 2'd0);
    assign bus.rsp_id    = fifo_id[rd_ptr];
    assign bus.rsp_data  = fifo_data[rd_ptr];
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr   <= ID_WIDTH'(NUM_REQ - 1);
            s1_valid <= 1'b0;
            s1_id    <= '0;
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            count    <= 2'd0;
        end else begin
            s1_valid <= grant_any;
            if (grant_any) begin
                rr_ptr <= grant_id;
                s1_id  <= grant_id;
            end
            // ROM output is valid one cycle after enable; land it directly in the FIFO.
            if (s1_valid) begin
                fifo_id[wr_ptr]   <= s1_id;
                fifo_data[wr_ptr] <= rom_data_out;
                wr_ptr            <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            case ({s1_valid, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule
